// File: rtl/gradient_frame_sequencer.sv
// Per-frame controller for the gradient datapath: flushes the datapath line buffers, streams one
// frame from the ping-pong frame store in raster order, counts returned gradient beats, then
// pulses done and swaps the current/previous banks.
// Ports:
//   clk_i, rst_i       clock and synchronous active-high reset
//   start_i            start one frame (accepted only while idle)
//   stall_i            downstream back-pressure; blocks new reads while streaming
//   grad_valid_i       gradient_compute output beat
//   mem_rd_en_o        frame-store read strobe (combinational: streaming and not stalled)
//   mem_rd_addr_o      raster read address 0..W*H-1
//   curr_bank_o        bank holding the current frame; previous frame is ~curr_bank_o
//   pixel_valid_o      mem_rd_en_o delayed by READ_LAT cycles
//   dp_rst_n_o         active-low reset to gradient_compute, low while flushing
//   busy_o, done_o     frame in progress / one-cycle end-of-frame pulse
//   grad_count_o       gradient beats counted this frame (saturates at the expected count)
//   err_o              sticky drain timeout or count overflow, cleared on accepted start
module gradient_frame_sequencer #(
  parameter int IMG_WIDTH     = 320,
  parameter int IMG_HEIGHT    = 240,
  parameter int BORDER        = 2,
  parameter int READ_LAT      = 1,
  parameter int FLUSH_CYCLES  = 2,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int ADDR_W        = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              grad_valid_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  output logic              curr_bank_o,
  output logic              pixel_valid_o,
  output logic              dp_rst_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] grad_count_o,
  output logic              err_o
);

  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int EXP  = (IMG_WIDTH - 2 * BORDER) * (IMG_HEIGHT - 2 * BORDER);
  localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
  localparam int DR_W = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] EXP_CNT    = ADDR_W'(EXP);
  localparam logic [FL_W-1:0]   FLUSH_LAST = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [DR_W-1:0]   DRAIN_LAST = DR_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                curr_bank_q;
  logic [READ_LAT-1:0] pv_q;
  logic                dp_rst_n_q;
  logic                busy_q;
  logic                done_q;
  logic [ADDR_W-1:0]   grad_count_q;
  logic [ADDR_W-1:0]   grad_count_d;
  logic                err_q;
  logic [FL_W-1:0]     flush_cnt_q;
  logic [DR_W-1:0]     drain_cnt_q;

  logic rd_en;
  logic count_en;
  logic ovf;

  // Reads are issued in the same cycle stall is low; the address register only advances on a read.
  assign rd_en    = (state_q == S_STREAM) && !stall_i;
  assign count_en = grad_valid_i && ((state_q == S_STREAM) || (state_q == S_DRAIN));

  // Gradient beat counter saturates at the expected count; a beat beyond it is an overflow.
  always_comb begin
    grad_count_d = grad_count_q;
    ovf          = 1'b0;
    if (count_en) begin
      if (grad_count_q == EXP_CNT) begin
        ovf = 1'b1;
      end else begin
        grad_count_d = grad_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      curr_bank_q  <= 1'b0;
      pv_q         <= '0;
      dp_rst_n_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      grad_count_q <= '0;
      err_q        <= 1'b0;
      flush_cnt_q  <= '0;
      drain_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;

      // pixel_valid pipe shifts every cycle so in-flight reads drain after streaming ends.
      pv_q[0] <= rd_en;
      for (int i = 1; i < READ_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
      end

      grad_count_q <= grad_count_d;
      if (ovf) begin
        err_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q      <= S_FLUSH;
            grad_count_q <= '0;
            err_q        <= 1'b0;
            dp_rst_n_q   <= 1'b0;
            busy_q       <= 1'b1;
            flush_cnt_q  <= '0;
            addr_q       <= '0;
          end
        end

        S_FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_q    <= S_STREAM;
            dp_rst_n_q <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end

        S_STREAM: begin
          if (rd_en) begin
            if (addr_q == LAST_ADDR) begin
              addr_q      <= '0;
              drain_cnt_q <= '0;
              state_q     <= S_DRAIN;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end

        S_DRAIN: begin
          drain_cnt_q <= drain_cnt_q + 1'b1;
          // Finish as soon as the count reaches the expected value, or give up after the timeout.
          if (grad_count_d == EXP_CNT) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (drain_cnt_q == DRAIN_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end

        S_DONE: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          curr_bank_q <= ~curr_bank_q;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd_en_o   = rd_en;
  assign mem_rd_addr_o = addr_q;
  assign curr_bank_o   = curr_bank_q;
  assign pixel_valid_o = pv_q[READ_LAT-1];
  assign dp_rst_n_o    = dp_rst_n_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign grad_count_o  = grad_count_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_gradient_frame_sequencer.sv
// Bench for gradient_frame_sequencer on an 8x6 frame (border 2, 8 expected gradient beats).
// Expected read addresses and per-frame results are queued when a frame is launched and popped
// as reads and done pulses appear.
module tb_gradient_frame_sequencer;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int B    = 2;
  localparam int RL   = 1;
  localparam int FC   = 2;
  localparam int DT   = 64;
  localparam int AW   = $clog2(W * H);
  localparam int NPIX = W * H;
  localparam int EXP  = (W - 2 * B) * (H - 2 * B);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stall;
  logic          grad_valid;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic          curr_bank;
  logic          pixel_valid;
  logic          dp_rst_n;
  logic          busy;
  logic          done;
  logic [AW-1:0] grad_count;
  logic          err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cnt;
    bit err;
    bit bank;
  } res_t;

  res_t exp_res[$];
  int   exp_addr[$];
  bit   pv_pipe[$];
  bit   bank_model;

  // Observations from the most recent frame.
  int r_reads, r_first_rd, r_last_rd, r_dp_low, r_done_cyc, r_done_pulses, r_cnt;
  bit r_err, r_got_done, r_bank_after, r_busy_after, r_dp_after;

  always #5 clk = ~clk;

  gradient_frame_sequencer #(
    .IMG_WIDTH    (W),
    .IMG_HEIGHT   (H),
    .BORDER       (B),
    .READ_LAT     (RL),
    .FLUSH_CYCLES (FC),
    .DRAIN_TIMEOUT(DT),
    .ADDR_W       (AW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .stall_i      (stall),
    .grad_valid_i (grad_valid),
    .mem_rd_en_o  (mem_rd_en),
    .mem_rd_addr_o(mem_rd_addr),
    .curr_bank_o  (curr_bank),
    .pixel_valid_o(pixel_valid),
    .dp_rst_n_o   (dp_rst_n),
    .busy_o       (busy),
    .done_o       (done),
    .grad_count_o (grad_count),
    .err_o        (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int n_exp_cnt, input bit n_exp_err);
    res_t r;
    for (int a = 0; a < NPIX; a++) exp_addr.push_back(a);
    bank_model = ~bank_model;
    r.cnt  = n_exp_cnt;
    r.err  = n_exp_err;
    r.bank = bank_model;
    exp_res.push_back(r);
  endtask

  // Drives one frame: start at cycle 0, optional stall every stall_per cycles, n_grad beats from
  // cycle 5, optional stray starts. Read addresses and pixel_valid are scoreboarded per cycle.
  task automatic run_frame(input int n_grad, input int stall_per, input int mid_start_cyc,
                           input bit start_in_done);
    int beats;
    int done_iter;
    int ea;
    bit e;
    beats = 0; done_iter = 0;
    r_reads = 0; r_first_rd = -1; r_last_rd = -1; r_dp_low = 0; r_done_cyc = -1;
    r_done_pulses = 0; r_cnt = -1; r_err = 1'b0; r_got_done = 1'b0;
    pv_pipe.delete();
    for (int c = 0; c < 400; c++) begin
      if (r_got_done && c > done_iter + 3) break;
      start      = (c == 0) || (c == mid_start_cyc) || (start_in_done && r_got_done && c == done_iter + 1);
      stall      = (stall_per > 0) && (c % stall_per == stall_per - 1);
      grad_valid = (c >= 5) && (beats < n_grad);
      if (grad_valid) beats++;
      #1;
      if (pv_pipe.size() > 0) begin
        e = pv_pipe.pop_front();
        total++;
        if (pixel_valid !== e) begin
          bad++;
          $display("FAIL pixel_valid cyc=%0d got=%b exp=%b", c, pixel_valid, e);
        end
      end
      pv_pipe.push_back(mem_rd_en === 1'b1);
      if (stall) begin
        total++;
        if (mem_rd_en !== 1'b0) begin
          bad++;
          $display("FAIL stall_read cyc=%0d rd_en=%b exp=0", c, mem_rd_en);
        end
      end
      if (mem_rd_en === 1'b1) begin
        if (r_reads == 0) r_first_rd = c;
        r_last_rd = c;
        r_reads++;
        total++;
        if (exp_addr.size() == 0) begin
          bad++;
          $display("FAIL extra_read cyc=%0d addr=%0d exp=none", c, mem_rd_addr);
        end else begin
          ea = exp_addr.pop_front();
          if (mem_rd_addr !== AW'(ea)) begin
            bad++;
            $display("FAIL rd_addr cyc=%0d got=%0d exp=%0d", c, mem_rd_addr, ea);
          end
        end
      end
      @(posedge clk);
      #1;
      if (dp_rst_n === 1'b0) r_dp_low++;
      if (done === 1'b1) begin
        r_done_pulses++;
        if (!r_got_done) begin
          r_got_done = 1'b1;
          done_iter  = c;
          r_done_cyc = c + 1;
          r_cnt      = int'(grad_count);
          r_err      = err;
        end
      end
    end
    start = 1'b0; stall = 1'b0; grad_valid = 1'b0;
    r_bank_after = curr_bank;
    r_busy_after = busy;
    r_dp_after   = dp_rst_n;
  endtask

  // Pops the expected result for the frame just run and compares the done-time outputs.
  task automatic check_result(input string tag);
    res_t r;
    total++;
    if (!r_got_done) begin
      bad++;
      $display("FAIL %s done_timeout got=no_done exp=done", tag);
    end
    if (exp_res.size() == 0) begin
      $display("test bench queue empty in %s", tag);
      return;
    end
    r = exp_res.pop_front();
    total++;
    if (r_cnt != r.cnt) begin
      bad++;
      $display("FAIL %s grad_count got=%0d exp=%0d", tag, r_cnt, r.cnt);
    end
    total++;
    if (r_err !== r.err) begin
      bad++;
      $display("FAIL %s err got=%b exp=%b", tag, r_err, r.err);
    end
    total++;
    if (r_bank_after !== r.bank) begin
      bad++;
      $display("FAIL %s curr_bank got=%b exp=%b", tag, r_bank_after, r.bank);
    end
    total++;
    if (r_done_pulses != 1) begin
      bad++;
      $display("FAIL %s done_pulses got=%0d exp=1", tag, r_done_pulses);
    end
    total++;
    if (r_reads != NPIX || exp_addr.size() != 0) begin
      bad++;
      $display("FAIL %s reads got=%0d exp=%0d left=%0d", tag, r_reads, NPIX, exp_addr.size());
    end
    exp_addr.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0; grad_valid = 1'b0;
    bank_model = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total++;
    if ({busy, done, mem_rd_en, pixel_valid, err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, mem_rd_en, pixel_valid, err});
    end
    total++;
    if (dp_rst_n !== 1'b1) begin
      bad++;
      $display("FAIL reset_dp_rst_n got=%b exp=1", dp_rst_n);
    end
    total++;
    if (curr_bank !== 1'b0) begin
      bad++;
      $display("FAIL reset_bank got=%b exp=0", curr_bank);
    end
    total++;
    if (mem_rd_addr !== '0 || grad_count !== '0) begin
      bad++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0", mem_rd_addr, grad_count);
    end
  endtask

  task automatic test_basic();
    push_frame(EXP, 1'b0);
    run_frame(EXP, 0, -1, 1'b0);
    check_result("basic");
    total++;
    if (r_dp_low != FC) begin
      bad++;
      $display("FAIL basic flush_len got=%0d exp=%0d", r_dp_low, FC);
    end
    total++;
    if (r_first_rd != FC + 1) begin
      bad++;
      $display("FAIL basic first_read_cyc got=%0d exp=%0d", r_first_rd, FC + 1);
    end
    total++;
    if (r_last_rd - r_first_rd != NPIX - 1) begin
      bad++;
      $display("FAIL basic back_to_back span got=%0d exp=%0d", r_last_rd - r_first_rd, NPIX - 1);
    end
  endtask

  task automatic test_stall();
    push_frame(EXP, 1'b0);
    run_frame(EXP, 3, -1, 1'b0);
    check_result("stall");
    total++;
    if (r_last_rd - r_first_rd <= NPIX - 1) begin
      bad++;
      $display("FAIL stall span got=%0d exp>%0d", r_last_rd - r_first_rd, NPIX - 1);
    end
  endtask

  task automatic test_timeout();
    push_frame(5, 1'b1);
    run_frame(5, 0, -1, 1'b0);
    check_result("timeout");
    total++;
    if (r_done_cyc - (r_last_rd + 1) != DT) begin
      bad++;
      $display("FAIL timeout drain_len got=%0d exp=%0d", r_done_cyc - (r_last_rd + 1), DT);
    end
  endtask

  task automatic test_overflow();
    push_frame(EXP, 1'b1);
    run_frame(EXP + 1, 0, -1, 1'b0);
    check_result("overflow");
  endtask

  task automatic test_start_ignored();
    push_frame(EXP, 1'b0);
    run_frame(EXP, 0, 20, 1'b1);
    check_result("start_ign");
    total++;
    if (r_dp_low != FC) begin
      bad++;
      $display("FAIL start_ign flush_len got=%0d exp=%0d", r_dp_low, FC);
    end
    total++;
    if (r_busy_after !== 1'b0 || r_dp_after !== 1'b1) begin
      bad++;
      $display("FAIL start_ign idle_after busy=%b dp_rst_n=%b exp=0/1", r_busy_after, r_dp_after);
    end
  endtask

  task automatic test_rst_mid();
    bit found;
    found = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (mem_rd_en === 1'b1 && mem_rd_addr === AW'(20)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL rst_mid reach_addr20 got=not_reached exp=reached");
    end
    rst = 1'b1;
    tick();
    total++;
    if ({busy, done, mem_rd_en, pixel_valid, err, curr_bank} !== 6'b0 || dp_rst_n !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid outputs got=%b dp_rst_n=%b exp=000000/1",
               {busy, done, mem_rd_en, pixel_valid, err, curr_bank}, dp_rst_n);
    end
    total++;
    if (mem_rd_addr !== '0 || grad_count !== '0) begin
      bad++;
      $display("FAIL rst_mid counts got=%0d/%0d exp=0/0", mem_rd_addr, grad_count);
    end
    rst = 1'b0;
    bank_model = 1'b0;
    tick();
    push_frame(EXP, 1'b0);
    run_frame(EXP, 0, -1, 1'b0);
    check_result("rst_mid_refill");
    total++;
    if (r_first_rd != FC + 1) begin
      bad++;
      $display("FAIL rst_mid first_read_cyc got=%0d exp=%0d", r_first_rd, FC + 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    repeat (2) tick();
    test_stall();
    repeat (2) tick();
    test_timeout();
    repeat (2) tick();
    test_overflow();
    repeat (2) tick();
    test_start_ignored();
    repeat (2) tick();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
